// File: rtl/alu_issue_unit.sv
// Issue front end for pipelined_alu: registers operands, tracks tags through the ALU
// pipeline, buffers responses in a credit-protected FIFO and supports flush/drain.

module alu_issue_unit_chk #(
    parameter int CW        = 3,
    parameter int RSP_DEPTH = 4
) (
    input logic          i_clk,
    input logic          i_rst,
    input logic          i_push,
    input logic [CW-1:0] i_count
);
    // The credit rule must make a capture into a full response FIFO impossible.
    a_no_capture_into_full: assert property (@(posedge i_clk) disable iff (i_rst)
        !(i_push && (i_count == CW'(RSP_DEPTH))));
endmodule

module alu_issue_unit #(
    parameter int WIDTH       = 16,
    parameter int ALU_LATENCY = 1,
    parameter int TAGW        = 4,
    parameter int RSP_DEPTH   = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [WIDTH-1:0] i_cmd_a,
    input  logic [WIDTH-1:0] i_cmd_b,
    input  logic [3:0]       i_cmd_op,
    input  logic [TAGW-1:0]  i_cmd_tag,
    output logic [WIDTH-1:0] o_alu_a,
    output logic [WIDTH-1:0] o_alu_b,
    output logic [3:0]       o_alu_op,
    input  logic [WIDTH-1:0] i_alu_result,
    input  logic             i_alu_overflow,
    input  logic             i_alu_underflow,
    input  logic             i_alu_invalid_op,
    input  logic             i_alu_is_equal,
    input  logic             i_alu_is_less,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic [WIDTH-1:0] o_rsp_result,
    output logic [4:0]       o_rsp_flags,
    output logic [TAGW-1:0]  o_rsp_tag,
    input  logic             i_flush,
    output logic             o_drained,
    output logic [15:0]      o_issued_count
);
    localparam int PIPE = ALU_LATENCY + 1;
    localparam int PW   = $clog2(RSP_DEPTH);
    localparam int CW   = PW + 1;

    typedef enum logic {ST_RUN = 1'b0, ST_DRAIN = 1'b1} state_t;

    function automatic logic [3:0] popcount(input logic [PIPE-1:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < PIPE; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_drained;
    logic              w_drained_nxt;
    logic [WIDTH-1:0]  r_alu_a;
    logic [WIDTH-1:0]  r_alu_b;
    logic [3:0]        r_alu_op;
    logic [15:0]       r_issued_count;
    logic [PIPE-1:0]   r_tag_vld;
    logic [TAGW-1:0]   r_tag [PIPE];
    logic [WIDTH-1:0]  r_fifo_result [RSP_DEPTH];
    logic [4:0]        r_fifo_flags [RSP_DEPTH];
    logic [TAGW-1:0]   r_fifo_tag [RSP_DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;

    logic [3:0]        w_inflight;
    logic [7:0]        w_used;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic              w_idle;

    // Credits are counted only from registered state, so rsp_ready never reaches cmd_ready.
    assign w_inflight  = popcount(r_tag_vld);
    assign w_used      = 8'(w_inflight) + 8'(r_count);
    assign o_cmd_ready = (r_state == ST_RUN) && (w_used < 8'(RSP_DEPTH));
    assign w_accept    = i_cmd_valid && o_cmd_ready;
    assign w_push      = r_tag_vld[PIPE-1];
    assign w_pop       = o_rsp_valid && i_rsp_ready;
    assign w_idle      = (w_inflight == 4'd0) && (r_count == CW'(0));

    assign o_alu_a        = r_alu_a;
    assign o_alu_b        = r_alu_b;
    assign o_alu_op       = r_alu_op;
    assign o_issued_count = r_issued_count;
    assign o_drained      = r_drained;
    assign o_rsp_valid    = (r_count != CW'(0));
    assign o_rsp_result   = r_fifo_result[r_rd_ptr];
    assign o_rsp_flags    = r_fifo_flags[r_rd_ptr];
    assign o_rsp_tag      = r_fifo_tag[r_rd_ptr];

    // Operand/opcode registers and the accepted-command counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_alu_a        <= '0;
            r_alu_b        <= '0;
            r_alu_op       <= 4'b0000;
            r_issued_count <= 16'd0;
        end else if (w_accept) begin
            r_alu_a        <= i_cmd_a;
            r_alu_b        <= i_cmd_b;
            r_alu_op       <= i_cmd_op;
            r_issued_count <= r_issued_count + 16'd1;
        end
    end

    // Tag shift register aligned with the ALU pipeline; the last stage marks a capture.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tag_vld <= '0;
            for (int i = 0; i < PIPE; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            r_tag_vld <= {r_tag_vld[PIPE-2:0], w_accept};
            r_tag[0]  <= i_cmd_tag;
            for (int i = 1; i < PIPE; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    // Response FIFO storage; a slot being popped may be rewritten on the same edge.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo_result[r_wr_ptr] <= i_alu_result;
            r_fifo_flags[r_wr_ptr]  <= {i_alu_invalid_op, i_alu_is_less, i_alu_is_equal,
                                        i_alu_underflow, i_alu_overflow};
            r_fifo_tag[r_wr_ptr]    <= r_tag[PIPE-1];
        end
    end

    // Response FIFO pointers and occupancy.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Flush/drain next-state and drained pulse.
    always_comb begin
        w_state_nxt   = r_state;
        w_drained_nxt = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (i_flush) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (w_idle) begin
                    w_state_nxt   = ST_RUN;
                    w_drained_nxt = 1'b1;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // Flush/drain state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_RUN;
            r_drained <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_drained <= w_drained_nxt;
        end
    end

    alu_issue_unit_chk #(
        .CW        (CW),
        .RSP_DEPTH (RSP_DEPTH)
    ) u_chk (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_count (r_count)
    );
endmodule

// File: tb/tb_alu_issue_unit.sv
// Self-checking bench for alu_issue_unit: a behavioural ALU stand-in plus an
// in-order expected-response queue built from each accepted command.

module tb_alu_issue_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_a;
    logic [15:0] cmd_b;
    logic [3:0]  cmd_op;
    logic [3:0]  cmd_tag;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_op;
    logic [20:0] alu_out = 21'd0;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_result;
    logic [4:0]  rsp_flags;
    logic [3:0]  rsp_tag;
    logic        flush;
    logic        drained;
    logic [15:0] issued_count;

    logic [24:0] exp_q[$];
    logic [24:0] got_q[$];
    int          errors = 0;
    int          checks = 0;
    int          acc_total = 0;

    always #5 clk = ~clk;

    alu_issue_unit dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_cmd_valid      (cmd_valid),
        .o_cmd_ready      (cmd_ready),
        .i_cmd_a          (cmd_a),
        .i_cmd_b          (cmd_b),
        .i_cmd_op         (cmd_op),
        .i_cmd_tag        (cmd_tag),
        .o_alu_a          (alu_a),
        .o_alu_b          (alu_b),
        .o_alu_op         (alu_op),
        .i_alu_result     (alu_out[15:0]),
        .i_alu_overflow   (alu_out[16]),
        .i_alu_underflow  (alu_out[17]),
        .i_alu_is_equal   (alu_out[18]),
        .i_alu_is_less    (alu_out[19]),
        .i_alu_invalid_op (alu_out[20]),
        .o_rsp_valid      (rsp_valid),
        .i_rsp_ready      (rsp_ready),
        .o_rsp_result     (rsp_result),
        .o_rsp_flags      (rsp_flags),
        .o_rsp_tag        (rsp_tag),
        .i_flush          (flush),
        .o_drained        (drained),
        .o_issued_count   (issued_count)
    );

    // ALU behaviour: returns {invalid, less, equal, underflow, overflow, result}.
    function automatic logic [20:0] alu_model(input logic [15:0] a, input logic [15:0] b,
                                              input logic [3:0] op);
        logic [16:0] wide;
        logic [15:0] r;
        logic [4:0]  f;
        r = 16'h0000;
        f = 5'b00000;
        wide = {1'b0, a} + {1'b0, b};
        case (op)
            4'd0: begin r = wide[15:0]; f[0] = wide[16]; end
            4'd1: begin r = a - b; f[1] = (a < b); end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: begin f[2] = (a == b); f[3] = (a < b); end
            default: f[4] = 1'b1;
        endcase
        return {f, r};
    endfunction

    // One-cycle ALU stand-in.
    always @(posedge clk) alu_out <= alu_model(alu_a, alu_b, alu_op);

    // Reference: every accept appends its expected response; every pop is recorded.
    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            got_q.delete();
            acc_total <= 0;
        end else begin
            if (cmd_valid && cmd_ready) begin
                exp_q.push_back({alu_model(cmd_a, cmd_b, cmd_op), cmd_tag});
                acc_total <= acc_total + 1;
            end
            if (rsp_valid && rsp_ready) got_q.push_back({rsp_flags, rsp_result, rsp_tag});
        end
    end

    task automatic present(input logic [15:0] a, input logic [15:0] b,
                           input logic [3:0] op, input logic [3:0] tag);
        cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op; cmd_tag = tag;
    endtask

    task automatic wait_rsp(input int n, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 80; c++) begin
            if (got_q.size() >= n) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; cmd_a = 16'd0; cmd_b = 16'd0; cmd_op = 4'd0;
        cmd_tag = 4'd0; rsp_ready = 1'b1; flush = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
        checks++; if (drained !== 1'b0) begin errors++; $display("FAIL reset_drained got=%b want=0", drained); end
        checks++; if (issued_count !== 16'd0) begin errors++; $display("FAIL reset_issued got=%0d want=0", issued_count); end
        checks++; if ({alu_a, alu_b, alu_op} !== 36'd0) begin errors++; $display("FAIL reset_alu got=%h/%h/%h want=0", alu_a, alu_b, alu_op); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got=%b want=1", cmd_ready); end
    endtask

    task automatic test_single_add();
        present(16'd100, 16'd200, 4'b0000, 4'd3);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL add_ready got=%b want=1", cmd_ready); end
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++; if ({alu_a, alu_b, alu_op} !== {16'd100, 16'd200, 4'd0}) begin errors++; $display("FAIL add_alu_regs got=%0d/%0d/%0d want=100/200/0", alu_a, alu_b, alu_op); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL add_early1 got=%b want=0", rsp_valid); end
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL add_early2 got=%b want=0", rsp_valid); end
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL add_latency got=%b want=1", rsp_valid); end
        checks++; if ({rsp_result, rsp_flags, rsp_tag} !== {16'd300, 5'b00000, 4'd3}) begin errors++; $display("FAIL add_rsp got=%0d/%b/%0d want=300/00000/3", rsp_result, rsp_flags, rsp_tag); end
        checks++; if (issued_count !== 16'd1) begin errors++; $display("FAIL add_issued got=%0d want=1", issued_count); end
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0 || got_q.size() != 1) begin errors++; $display("FAIL add_pop got valid=%b pops=%0d want 0/1", rsp_valid, got_q.size()); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] ta [4];
        logic [15:0] tb [4];
        logic [3:0]  to [4];
        bit ok;
        ta = '{16'd50, 16'hFF00, 16'hAAAA, 16'h1234};
        tb = '{16'd80, 16'h0F0F, 16'hFFFF, 16'h5678};
        to = '{4'd1, 4'd2, 4'd4, 4'b1111};
        exp_q.delete(); got_q.delete();
        for (int i = 0; i < 4; i++) begin
            present(ta[i], tb[i], to[i], 4'(i));
            checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got=%b want=1", i, cmd_ready); end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        wait_rsp(4, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL b2b_timeout got=%0d rsps want=4", got_q.size()); end
        else begin
            checks++; if (got_q[0][19:4] !== 16'hFFE2 || got_q[0][21] !== 1'b1) begin errors++; $display("FAIL b2b_sub got=%h flags=%b want=FFE2 uf=1", got_q[0][19:4], got_q[0][24:20]); end
            checks++; if (got_q[1][19:4] !== 16'h0F00) begin errors++; $display("FAIL b2b_and got=%h want=0F00", got_q[1][19:4]); end
            checks++; if (got_q[2][19:4] !== 16'h5555) begin errors++; $display("FAIL b2b_xor got=%h want=5555", got_q[2][19:4]); end
            checks++; if (got_q[3][24] !== 1'b1) begin errors++; $display("FAIL b2b_invalid got=%b want=1", got_q[3][24]); end
            for (int i = 0; i < 4; i++) begin
                checks++; if (got_q[i][3:0] !== 4'(i) || got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_order[%0d] got=%h want=%h", i, got_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_backpressure(input int ncmd, input int nhold);
        int idx, stable_bad, stall;
        bit have_head, ok;
        logic [24:0] head;
        exp_q.delete(); got_q.delete();
        rsp_ready = 1'b0; idx = 0; stable_bad = 0; have_head = 1'b0; head = '0; stall = 0;
        for (int c = 0; c < 12; c++) begin
            present(16'($urandom), 16'($urandom), 4'($urandom_range(0, 7)), 4'($urandom));
            if (cmd_ready) idx++;
            @(negedge clk);
            if (rsp_valid && !have_head) begin head = {rsp_flags, rsp_result, rsp_tag}; have_head = 1'b1; end
            else if (have_head && {rsp_flags, rsp_result, rsp_tag} !== head) stable_bad++;
        end
        checks++; if (idx != 4 || exp_q.size() != 4) begin errors++; $display("FAIL bp_accepted got=%0d want=4", exp_q.size()); end
        checks++; if (cmd_ready !== 1'b0 || rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_full got ready=%b valid=%b want 0/1", cmd_ready, rsp_valid); end
        checks++; if (stable_bad != 0 || head !== exp_q[0]) begin errors++; $display("FAIL bp_head_stable got=%h changes=%0d want=%h", head, stable_bad, exp_q[0]); end
        rsp_ready = 1'b1;
        for (int c = 0; c < 3 * ncmd && idx < ncmd; c++) begin
            present(16'($urandom), 16'($urandom), 4'($urandom_range(0, 7)), 4'($urandom));
            if (cmd_ready) idx++;
            @(negedge clk);
            if (!rsp_valid && idx < ncmd && c < nhold) stall++;
        end
        cmd_valid = 1'b0;
        checks++; if (stall != 0) begin errors++; $display("FAIL bp_stream_gap got=%0d empty cycles want=0", stall); end
        wait_rsp(ncmd, ok);
        checks++; if (!ok || got_q.size() != ncmd || exp_q.size() != ncmd) begin errors++; $display("FAIL bp_count got=%0d exp=%0d want=%0d", got_q.size(), exp_q.size(), ncmd); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_order[%0d] got=%h want=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_flush();
        int pop_n, drn_n, drn_cnt, early_rdy;
        bit rdy_at_drn;
        exp_q.delete(); got_q.delete();
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            present(16'($urandom), 16'($urandom), 4'($urandom_range(0, 5)), 4'(i + 8));
            flush = (i == 2);
            @(negedge clk);
        end
        cmd_valid = 1'b0; flush = 1'b0;
        checks++; if (cmd_ready !== 1'b0 || exp_q.size() != 3) begin errors++; $display("FAIL flush_ready got ready=%b acc=%0d want 0/3", cmd_ready, exp_q.size()); end
        flush = 1'b1;
        pop_n = -1; drn_n = -1; drn_cnt = 0; early_rdy = 0; rdy_at_drn = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (drained) begin drn_cnt++; drn_n = c; rdy_at_drn = cmd_ready; end
            else if (drn_cnt == 0 && cmd_ready) early_rdy++;
            if (rsp_valid && rsp_ready) pop_n = c;
            @(negedge clk);
            flush = 1'b0;
        end
        checks++; if (drn_cnt != 1) begin errors++; $display("FAIL flush_pulses got=%0d want=1", drn_cnt); end
        checks++; if (drn_n != pop_n + 2) begin errors++; $display("FAIL flush_timing got=%0d want=%0d", drn_n, pop_n + 2); end
        checks++; if (early_rdy != 0 || rdy_at_drn !== 1'b1) begin errors++; $display("FAIL flush_ready_window got early=%0d at_drn=%b want 0/1", early_rdy, rdy_at_drn); end
        checks++; if (got_q.size() != 3 || got_q[0] !== exp_q[0] || got_q[2] !== exp_q[2]) begin errors++; $display("FAIL flush_rsps got=%0d want=3 in order", got_q.size()); end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++; if (drained !== 1'b0 || cmd_ready !== 1'b0) begin errors++; $display("FAIL idle_flush_f got drn=%b rdy=%b want 0/0", drained, cmd_ready); end
        @(negedge clk);
        checks++; if (drained !== 1'b1 || cmd_ready !== 1'b1) begin errors++; $display("FAIL idle_flush_f1 got drn=%b rdy=%b want 1/1", drained, cmd_ready); end
        @(negedge clk);
        checks++; if (drained !== 1'b0) begin errors++; $display("FAIL idle_flush_pulse got=%b want=0", drained); end
    endtask

    task automatic test_reset_mid();
        int stale;
        bit ok;
        logic [24:0] want;
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            present(16'($urandom), 16'($urandom), 4'($urandom_range(0, 5)), 4'(i));
            @(negedge clk);
        end
        cmd_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (rsp_valid !== 1'b0 || issued_count !== 16'd0) begin errors++; $display("FAIL rstmid_state got valid=%b issued=%0d want 0/0", rsp_valid, issued_count); end
        stale = 0;
        repeat (6) begin @(negedge clk); if (rsp_valid) stale++; end
        checks++; if (stale != 0 || got_q.size() != 0) begin errors++; $display("FAIL rstmid_stale got=%0d want=0", stale); end
        present(16'd7, 16'd9, 4'd0, 4'd12);
        want = {5'b00000, 16'd16, 4'd12};
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_rsp(1, ok);
        checks++; if (!ok || got_q[0] !== want) begin errors++; $display("FAIL rstmid_next got=%h want=%h", ok ? got_q[0] : 25'h0, want); end
        checks++; if (issued_count !== 16'd1) begin errors++; $display("FAIL rstmid_issued got=%0d want=1", issued_count); end
    endtask

    task automatic test_random();
        bit ok;
        exp_q.delete(); got_q.delete();
        for (int c = 0; c < 300; c++) begin
            cmd_valid = ($urandom_range(0, 3) != 0);
            cmd_a = 16'($urandom); cmd_b = 16'($urandom);
            cmd_op = 4'($urandom); cmd_tag = 4'($urandom);
            rsp_ready = ($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 40) == 0);
            @(negedge clk);
        end
        cmd_valid = 1'b0; flush = 1'b0; rsp_ready = 1'b1;
        wait_rsp(exp_q.size(), ok);
        checks++; if (!ok || got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_rsp[%0d] got=%h want=%h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (issued_count !== 16'(acc_total)) begin errors++; $display("FAIL rand_issued got=%0d want=%0d", issued_count, acc_total); end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_back_to_back();
        test_backpressure(6, 0);
        test_backpressure(12, 12);
        test_flush();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
